// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// operand width, funct3 encodings and the controller state type.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide at the EX stage: 32-step shift-add multiply
// or restoring divide on magnitudes, sign-corrected on the final step.
module ex_muldiv_unit #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  import muldiv_pkg::*;

  state_e            state, state_nxt;
  logic [4:0]        cnt;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;    // multiply: {high, multiplier}; divide: {rem, quo}

  // Start-time decode: operand magnitudes, result sign, divide special cases.
  logic            is_div, a_signed, b_signed, sa, sb;
  logic            div_zero, div_ovf, special, accept;
  logic            neg_start;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    is_div   = funct3_i[2];
    a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
               (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    sa       = a_signed & op_a_i[XLEN-1];
    sb       = b_signed & op_b_i[XLEN-1];
    mag_a    = sa ? -op_a_i : op_a_i;
    mag_b    = sb ? -op_b_i : op_b_i;
    neg_start = (funct3_i == F3_REM) ? sa : (sa ^ sb);
    div_zero = is_div && (op_b_i == '0);
    div_ovf  = is_div && !funct3_i[0] &&
               (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    special  = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = funct3_i[1] ? op_a_i : '1;
    else if (div_ovf)
      special_res = funct3_i[1] ? '0 : op_a_i;
    accept   = (state == IDLE) && start_i && !flush_i;
  end

  // One iteration step and the sign-corrected result it would produce.
  logic [XLEN:0]     add_sum, shifted, trial;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   div_sel, final_res;

  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shifted = acc_q[2*XLEN-1:XLEN-1];
    trial   = shifted - {1'b0, opnd_q};
    if (funct3_q[2]) begin
      // A borrow out of the 33-bit trial means the divisor did not fit.
      if (trial[XLEN])
        acc_step = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
        acc_step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {add_sum, acc_q[XLEN-1:1]};
    end

    prod    = neg_q ? -acc_step : acc_step;
    div_sel = funct3_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    case (funct3_q)
      F3_MUL:                       final_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*XLEN-1:XLEN];
      default:                      final_res = neg_q ? -div_sel : div_sel;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
      BUSY:    if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  assign stall_o = accept || (state == BUSY);
  assign busy_o  = (state == BUSY);
  assign done_o  = (state == DONE) && !flush_i;

  // NOTE: sequential state is assigned with <= only, so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            funct3_q <= funct3_i;
            rd_q     <= rd_i;
            neg_q    <= neg_start;
            opnd_q   <= mag_b;
            acc_q    <= {{XLEN{1'b0}}, mag_a};
            cnt      <= '0;
            if (special) begin
              result_o <= special_res;
              rd_o     <= rd_i;
            end
          end
        end
        BUSY: begin
          if (!flush_i) begin
            acc_q <= acc_step;
            if (cnt == 5'd31) begin
              result_o <= final_res;
              rd_o     <= rd_q;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed spec cases, protocol timing,
// flush/reset interruption and randomized ops against an arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(signed'(a) / signed'(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(signed'(a) % signed'(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op in the current cycle and follows it to completion.
  // lat = cycles from the start cycle to the done cycle (40 if it never came).
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit poke,
                       output int lat, output logic [31:0] res, output logic [4:0] rdo,
                       output bit busy_seen, output bit proto_ok, output int done_cyc);
    int n;
    proto_ok  = 1'b1;
    busy_seen = 1'b0;
    funct3_i = f3; op_a_i = a; op_b_i = b; rd_i = rd; start_i = 1'b1;
    #1;
    if (stall_o !== 1'b1) proto_ok = 1'b0;
    tick();
    start_i = 1'b0;
    n = 1;
    while (done_o !== 1'b1 && n < 40) begin
      if (poke) begin
        start_i  = 1'($urandom);
        funct3_i = 3'($urandom);
        op_a_i   = $urandom;
        op_b_i   = $urandom;
        rd_i     = 5'($urandom);
        #1;
      end
      if (busy_o === 1'b1) busy_seen = 1'b1;
      if (stall_o !== busy_o) proto_ok = 1'b0;
      tick();
      n++;
    end
    lat      = n;
    done_cyc = cyc;
    res      = result_o;
    rdo      = rd_o;
    if (stall_o !== 1'b0) proto_ok = 1'b0;
    tick();
    start_i = 1'b0;
    #1;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || stall_o !== 1'b0) proto_ok = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; flush_i = 1'b0;
    funct3_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd4; rd_i = 5'd9;
    repeat (3) tick();
    start_i = 1'b0;
    #1;
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0 || rd_o !== 5'd0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h rd=%0d, required 0 0 0 0",
               busy_o, done_o, result_o, rd_o);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b stall=%b, required 0 0", busy_o, stall_o);
    end
  endtask

  task automatic test_mul_timing();
    int lat, dc; logic [31:0] res; logic [4:0] rdo; bit bs, pok;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd13, 1'b0, lat, res, rdo, bs, pok, dc);
    tests++;
    if (lat !== 33 || res !== 32'hFFFF_FFEB || rdo !== 5'd13 || !bs || !pok) begin
      fails++;
      $display("FAIL mul_timing: lat=%0d res=%h rd=%0d busy_seen=%b proto=%b, required 33 ffffffeb 13 1 1",
               lat, res, rdo, bs, pok);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  f3s [7] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs_ [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex  [7] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                             32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat, dc; logic [31:0] res; logic [4:0] rdo; bit bsn, pok;
    for (int i = 0; i < 7; i++) begin
      do_op(f3s[i], as[i], bs_[i], 5'(i + 1), 1'b1, lat, res, rdo, bsn, pok, dc);
      tests++;
      if (lat !== 33 || res !== ex[i] || rdo !== 5'(i + 1) || !pok) begin
        fails++;
        $display("FAIL directed_%0d f3=%0d: lat=%0d res=%h rd=%0d proto=%b, required 33 %h %0d 1",
                 i, f3s[i], lat, res, rdo, pok, ex[i], i + 1);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd20, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs_ [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'd20, 32'h8000_0000, 32'h0};
    int lat, dc; logic [31:0] res; logic [4:0] rdo; bit bsn, pok;
    for (int i = 0; i < 4; i++) begin
      do_op(f3s[i], as[i], bs_[i], 5'(20 + i), 1'b0, lat, res, rdo, bsn, pok, dc);
      tests++;
      if (lat !== 1 || bsn || res !== ex[i] || rdo !== 5'(20 + i)) begin
        fails++;
        $display("FAIL special_%0d f3=%0d: lat=%0d busy_seen=%b res=%h rd=%0d, required 1 0 %h %0d",
                 i, f3s[i], lat, bsn, res, rdo, ex[i], 20 + i);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int lat, dc; logic [31:0] res; logic [4:0] rdo; bit bsn, pok;
    prev = result_o;
    funct3_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd7; rd_i = 5'd30; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0 || result_o !== prev) begin
      fails++;
      $display("FAIL flush_abort: busy=%b done=%b stall=%b result=%h, required 0 0 0 %h",
               busy_o, done_o, stall_o, result_o, prev);
    end
    do_op(3'd5, 32'd100, 32'd7, 5'd17, 1'b0, lat, res, rdo, bsn, pok, dc);
    tests++;
    if (lat !== 33 || res !== 32'd14 || rdo !== 5'd17 || !pok) begin
      fails++;
      $display("FAIL flush_restart: lat=%0d res=%h rd=%0d proto=%b, required 33 0000000e 17 1",
               lat, res, rdo, pok);
    end
  endtask

  task automatic test_reset_mid();
    funct3_i = 3'd0; op_a_i = 32'd9; op_b_i = 32'd9; rd_i = 5'd4; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0 ||
        result_o !== 32'h0 || rd_o !== 5'd0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b stall=%b result=%h rd=%0d, required all 0",
               busy_o, done_o, stall_o, result_o, rd_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, dc1, dc2; logic [31:0] r1, r2; logic [4:0] d1, d2; bit b1, b2, p1, p2;
    do_op(3'd0, 32'd12345, 32'd678, 5'd7, 1'b0, lat1, r1, d1, b1, p1, dc1);
    do_op(3'd0, 32'hFFFF_FFFF, 32'd3, 5'd8, 1'b0, lat2, r2, d2, b2, p2, dc2);
    tests++;
    if (r1 !== 32'd8369910 || r2 !== 32'hFFFF_FFFD || d1 !== 5'd7 || d2 !== 5'd8) begin
      fails++;
      $display("FAIL b2b_results: r1=%h r2=%h rd1=%0d rd2=%0d, required 007fb6f6 fffffffd 7 8",
               r1, r2, d1, d2);
    end
    tests++;
    if (dc2 - dc1 !== 34 || !p1 || !p2) begin
      fails++;
      $display("FAIL b2b_spacing: spacing=%0d proto=%b%b, required 34 11", dc2 - dc1, p1, p2);
    end
  endtask

  task automatic test_random();
    int lat, dc, exp_lat; logic [31:0] res, a, b, exp; logic [4:0] rdo, rd; logic [2:0] f3;
    bit bsn, pok, spec;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = rand_operand();
      b  = rand_operand();
      rd = 5'($urandom);
      exp = ref_model(f3, a, b);
      spec = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_lat = spec ? 1 : 33;
      do_op(f3, a, b, rd, 1'b1, lat, res, rdo, bsn, pok, dc);
      tests++;
      if (res !== exp || rdo !== rd || lat !== exp_lat || !pok) begin
        fails++;
        $display("FAIL random_%0d f3=%0d a=%h b=%h: res=%h rd=%0d lat=%0d proto=%b, required %h %0d %0d 1",
                 i, f3, a, b, res, rdo, lat, pok, exp, rd, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_directed();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit at the read end of the ID/EX pipeline register. It consumes the operands, funct3 and destination register that ID/EX presents to the EX stage for M-extension instructions. It runs a 32-iteration shift-add multiply or restoring divide. While it runs, it holds the pipeline through a stall output.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start_i  input  1  ID/EX holds a valid M-extension op; sampled only in IDLE
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a_i  input  32  rs1 value (dataR1 from ID/EX)
- op_b_i  input  32  rs2 value (dataR2 from ID/EX)
- rd_i  input  5  destination register (rs_WB from ID/EX)
- flush_i  input  1  abort current op (branch/exception flush); priority below rst
- stall_o  output  1  freeze IF/ID and ID/EX; combinational
- busy_o  output  1  state is BUSY
- done_o  output  1  one-cycle pulse: result_o/rd_o valid
- result_o  output  32  final result; holds its value until the next DONE
- rd_o  output  5  latched rd for EX/MEM

## Operation
- Reset (rst=1 at an edge): state=IDLE; result_o=0; rd_o=0; done_o=0; busy_o=0; counter=0; all internal registers cleared.
- States: IDLE, BUSY, DONE.
- IDLE with start_i=1 and flush_i=0: latch funct3, rd and operands.
  - Signed ops (MULH, DIV, REM; op_a only for MULHSU): convert operands to magnitudes and record the result sign.
    - Multiply: sign = sa^sb.
    - Quotient: sign = sa^sb.
    - Remainder: sign = sa.
  - Normal case: go to BUSY with counter=0.
  - Special divide cases skip iteration and go directly to DONE:
    - Divide by zero: quotient=0xFFFFFFFF; remainder=op_a.
    - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000; remainder=0.
- BUSY: one iteration per cycle.
  - Multiply: 64-bit accumulator; add the multiplicand when the multiplier LSB is 1; shift right.
  - Divide: shift remainder:quotient left; trial-subtract the divisor; set the quotient bit when the result is non-negative.
  - When counter reaches 31, the iteration completes and the state goes to DONE on that same edge. result_o is loaded with the sign-corrected selection:
    - MUL: low 32 bits.
    - MULH*: high 32 bits.
    - DIV*: quotient.
    - REM*: remainder.
- DONE: done_o=1 for exactly one cycle, then IDLE. start_i is ignored in DONE.
- stall_o = (IDLE & start_i & ~flush_i) | BUSY. It is deasserted in DONE so that ID/EX advances on the edge that ends DONE.
- flush_i=1 in any state: next state is IDLE and done_o is not asserted. result_o keeps its old value. start_i in that same cycle is ignored.
- rst wins over flush_i and start_i.

## Timing
- start_i accepted at edge k:
  - busy_o=1 in cycles k+1..k+32.
  - done_o=1 in cycle k+33.
  - IDLE in cycle k+34; a new start can be accepted at the edge ending cycle k+34.
- Special divide cases: done_o=1 in cycle k+1; busy_o never asserts.
- result_o and rd_o change only on the edge that enters DONE.
- Output widths:
  - Product intermediate: 64 bits.
  - Remainder/quotient intermediate: 32 bits each, plus a 33-bit trial difference.
  - Counter: 5 bits; it does not wrap because it is reset on each start.

## Structure
- Shared package muldiv_pkg holds:
  - funct3 localparams (F3_MUL..F3_REMU);
  - state enum type (IDLE, BUSY, DONE);
  - XLEN.
- A single module is required; the datapath is small enough that no sub-module is warranted. The ID/EX-side hazard logic consumes stall_o and does not live here.

## Test plan
- MUL, 7 × 0xFFFFFFFD (−3), start at edge k -> done_o in cycle k+33, result_o=0xFFFFFFEB, rd_o=latched rd. stall_o high in cycle k and in cycles k+1..k+32; low in cycle k+33.
- MULHU and MULH, 0xFFFFFFFF × 0xFFFFFFFF -> MULHU result 0xFFFFFFFE; MULH result 0x00000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Special cases -> done_o in cycle k+1 with busy_o never high:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 20/0 -> 20.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- flush_i at cycle k+10 of a DIV -> IDLE next cycle; no done_o; result_o unchanged. A start in the following cycle is accepted and completes with the correct value.
- rst asserted at cycle k+5 of a MUL -> all outputs 0 at the next cycle and state IDLE. Back-to-back MUL starts issued immediately after IDLE -> both results correct, spaced 34 cycles apart.
